async_transmitter: RTL and testbench

Byte-serial UART transmitter: the transmit side paired with `async_receiver` on the same RS-232 link. It accepts bytes over a valid/ready handshake into a small FIFO and serializes each one on `TxD` as 8N1 framing by default, LSB first. Optional parity and a second stop bit are available. It contains its own bit-period divider, so it needs no external tick and transmits back-to-back frames with no idle gap.

---
 rtl/async_transmitter.sv | 178 +++++++++++++++++
 tb/tb_async_transmitter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/async_transmitter.sv
// rtl/async_transmitter.sv - UART transmitter with byte FIFO, bit-period divider, optional parity and second stop bit
module async_transmitter #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int FifoDepth    = 4,
   parameter int ParityEn     = 0,
   parameter int ParityOdd    = 0,
   parameter int StopBits     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tx_valid,
   input  logic [7:0]                   tx_data,
   output logic                         tx_ready,
   output logic                         TxD,
   output logic                         tx_busy,
   output logic [$clog2(FifoDepth):0]   fifo_count
);

   localparam int Divisor = (ClkFrequency + Baud / 2) / Baud;
   localparam int AddrW   = $clog2(FifoDepth);
   localparam int CountW  = AddrW + 1;
   localparam int DivW    = (Divisor > 1) ? $clog2(Divisor) : 1;
   localparam logic OddBit = (ParityOdd != 0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   if (Divisor < 2) begin : gDivisorCheck
      $error("async_transmitter: Divisor must be at least 2");
   end
   if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : gFifoDepthCheck
      $error("async_transmitter: FifoDepth must be a power of 2 and at least 2");
   end
   if ((StopBits != 1) && (StopBits != 2)) begin : gStopBitsCheck
      $error("async_transmitter: StopBits must be 1 or 2");
   end

   logic [7:0]      mem [FifoDepth];
   logic [AddrW:0]  wrPtr;
   logic [AddrW:0]  rdPtr;
   logic [7:0]      head;
   logic [2:0]      state;
   logic [DivW-1:0] divCnt;
   logic [7:0]      shift;
   logic [2:0]      bitIdx;
   logic            parity;
   logic            stopCnt;
   logic            txdReg;
   logic            push;
   logic            pop;
   logic            notEmpty;
   logic            bitTick;
   logic            lastStop;

   // Pointers carry one extra wrap bit, so their difference is the occupancy directly.
   assign fifo_count = wrPtr - rdPtr;
   assign notEmpty   = (fifo_count != '0);
   assign tx_ready   = (fifo_count != CountW'(FifoDepth));
   assign push       = tx_valid && tx_ready;
   assign head       = mem[rdPtr[AddrW-1:0]];
   assign bitTick    = (state != IDLE) && (divCnt == DivW'(Divisor - 1));
   assign lastStop   = (stopCnt == 1'(StopBits - 1));
   // A byte leaves the FIFO either from idle or straight out of the final stop bit.
   assign pop        = notEmpty && ((state == IDLE) || ((state == STOP) && bitTick && lastStop));
   assign tx_busy    = (state != IDLE) || notEmpty;
   assign TxD        = txdReg;

   // FIFO storage: written on an accepted push, no reset needed for the data itself.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr[AddrW-1:0]] <= tx_data;
      end
   end

   // FIFO pointers advance independently, so push and pop may share an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
      end
   end

   // Frame sequencer with its bit-period divider; TxD is registered alongside the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         divCnt  <= '0;
         shift   <= '0;
         bitIdx  <= '0;
         parity  <= 1'b0;
         stopCnt <= 1'b0;
         txdReg  <= 1'b1;
      end else begin
         if (state != IDLE) begin
            divCnt <= bitTick ? '0 : divCnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (notEmpty) begin
                  shift  <= head;
                  bitIdx <= '0;
                  parity <= 1'b0;
                  divCnt <= '0;
                  state  <= START;
                  txdReg <= 1'b0;
               end
            end
            START: begin
               if (bitTick) begin
                  state  <= DATA;
                  txdReg <= shift[0];
               end
            end
            DATA: begin
               if (bitTick) begin
                  parity <= parity ^ shift[0];
                  shift  <= {1'b0, shift[7:1]};
                  if (bitIdx == 3'd7) begin
                     if (ParityEn != 0) begin
                        state  <= PARITY;
                        txdReg <= parity ^ shift[0] ^ OddBit;
                     end else begin
                        state   <= STOP;
                        stopCnt <= 1'b0;
                        txdReg  <= 1'b1;
                     end
                  end else begin
                     bitIdx <= bitIdx + 1'b1;
                     txdReg <= shift[1];
                  end
               end
            end
            PARITY: begin
               if (bitTick) begin
                  state   <= STOP;
                  stopCnt <= 1'b0;
                  txdReg  <= 1'b1;
               end
            end
            STOP: begin
               if (bitTick) begin
                  if (lastStop) begin
                     if (notEmpty) begin
                        shift  <= head;
                        bitIdx <= '0;
                        parity <= 1'b0;
                        divCnt <= '0;
                        state  <= START;
                        txdReg <= 1'b0;
                     end else begin
                        state  <= IDLE;
                        txdReg <= 1'b1;
                     end
                  end else begin
                     stopCnt <= stopCnt + 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               txdReg <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_async_transmitter.sv
// tb/tb_async_transmitter.sv - scoreboard bench for async_transmitter in four framing configurations
module tb_async_transmitter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       txValid [4];
   logic [7:0] txData  [4];
   logic       txReady [4];
   logic       txd     [4];
   logic       busy    [4];
   logic [2:0] cnt     [4];

   int pe  [4] = '{0, 1, 1, 0};
   int po  [4] = '{0, 0, 1, 0};
   int sbn [4] = '{1, 1, 1, 2};

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int rstEpoch = 0;
   int starts  [4][16];
   int nStarts [4] = '{0, 0, 0, 0};
   logic [15:0] sb [$];

   async_transmitter #(.ClkFrequency(1600000), .Baud(100000), .FifoDepth(4),
                       .ParityEn(0), .ParityOdd(0), .StopBits(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid[0]), .tx_data(txData[0]),
      .tx_ready(txReady[0]), .TxD(txd[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
   async_transmitter #(.ClkFrequency(1600000), .Baud(100000), .FifoDepth(4),
                       .ParityEn(1), .ParityOdd(0), .StopBits(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid[1]), .tx_data(txData[1]),
      .tx_ready(txReady[1]), .TxD(txd[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
   async_transmitter #(.ClkFrequency(1600000), .Baud(100000), .FifoDepth(4),
                       .ParityEn(1), .ParityOdd(1), .StopBits(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid[2]), .tx_data(txData[2]),
      .tx_ready(txReady[2]), .TxD(txd[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
   async_transmitter #(.ClkFrequency(1600000), .Baud(100000), .FifoDepth(4),
                       .ParityEn(0), .ParityOdd(0), .StopBits(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .tx_valid(txValid[3]), .tx_data(txData[3]),
      .tx_ready(txReady[3]), .TxD(txd[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Line bits in send order: bit 0 is the start bit, unused upper bits stay high.
   function automatic logic [11:0] frameBits(input int k, input logic [7:0] b);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = b;
      if (pe[k] != 0) f[9] = (^b) ^ (po[k] != 0);
      return f;
   endfunction

   task automatic sendByte(input int k, input logic [7:0] b, output int accEdge);
      int n;
      n = 0;
      accEdge = -1;
      @(negedge clk);
      txValid[k] = 1'b1;
      txData[k]  = b;
      while (!txReady[k] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!txReady[k]) begin
         checkEq($sformatf("push_timeout_%0d", k), txReady[k], 1);
      end else begin
         accEdge = cyc + 1;
         sb.push_back({k[3:0], frameBits(k, b)});
         @(posedge clk);
         #1;
      end
      txValid[k] = 1'b0;
   endtask

   task automatic waitIdle(input int k, output int fallEdge);
      int n;
      n = 0;
      while (busy[k] && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkEq($sformatf("idle_timeout_%0d", k), busy[k], 0);
      fallEdge = cyc;
   endtask

   task automatic drain(input int k);
      int f;
      waitIdle(k, f);
      repeat (20) @(negedge clk);
      checkEq($sformatf("sb_drained_%0d", k), sb.size(), 0);
   endtask

   // Decodes frames off one line by sampling mid-bit and compares them against the scoreboard.
   task automatic monitor(input int k);
      forever begin
         @(negedge clk);
         if (txd[k] === 1'b0) begin
            int s;
            int ep;
            int nb;
            logic [11:0] fr;
            logic [15:0] e;
            bit aborted;
            s = cyc;
            ep = rstEpoch;
            nb = 9 + pe[k] + sbn[k];
            fr = '1;
            aborted = 0;
            if (nStarts[k] < 16) starts[k][nStarts[k]] = s;
            nStarts[k]++;
            for (int i = 0; i < nb; i++) begin
               while (cyc != s + 16 * i + 8 && rstEpoch == ep) @(negedge clk);
               if (rstEpoch != ep) begin
                  aborted = 1;
                  break;
               end
               fr[i] = txd[k];
            end
            if (!aborted) begin
               if (sb.size() == 0) begin
                  checkEq($sformatf("frame_unexpected_%0d", k), {20'd0, fr}, 32'hfff);
               end else begin
                  e = sb.pop_front();
                  checkEq($sformatf("frame_owner_%0d", k), e[15:12], k);
                  checkEq($sformatf("frame_bits_%0d", k), fr, e[11:0]);
               end
               while (cyc < s + 16 * nb - 1 && rstEpoch == ep) @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      int a;
      int f;
      int base;
      int lows;
      int acc [6];
      logic [7:0] burst [6];
      burst = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h42};
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         txValid[k] = 1'b0;
         txData[k]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) checkEq($sformatf("reset_txd_%0d", k), txd[k], 1);
      checkEq("reset_ready", txReady[0], 1);
      checkEq("reset_busy", busy[0], 0);
      checkEq("reset_count", cnt[0], 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      fork
         monitor(0);
         monitor(1);
         monitor(2);
         monitor(3);
      join_none

      // single byte: start bit from the edge after acceptance, busy for 160 cycles of frame
      base = nStarts[0];
      sendByte(0, 8'h55, a);
      @(negedge clk);
      checkEq("single_busy_rise", busy[0], 1);
      checkEq("single_count", cnt[0], 1);
      checkEq("single_txd_before_pop", txd[0], 1);
      waitIdle(0, f);
      checkEq("single_start_edge", starts[0][base], a + 1);
      checkEq("single_busy_fall", f, a + 161);
      drain(0);

      // burst with backpressure: five accepted back to back, sixth after the first pop
      base = nStarts[0];
      for (int i = 0; i < 6; i++) begin
         sendByte(0, burst[i], acc[i]);
         if (i == 4) begin
            @(negedge clk);
            checkEq("burst_full_count", cnt[0], 4);
            checkEq("burst_full_ready", txReady[0], 0);
         end
      end
      for (int i = 1; i < 5; i++) checkEq($sformatf("burst_accept_%0d", i), acc[i], acc[0] + i);
      checkEq("burst_accept_5", acc[5], acc[0] + 162);
      waitIdle(0, f);
      checkEq("burst_first_start", starts[0][base], acc[0] + 1);
      for (int i = 1; i < 6; i++)
         checkEq($sformatf("burst_gap_%0d", i), starts[0][base + i] - starts[0][base + i - 1], 160);
      drain(0);

      // even parity: 11-bit frame
      sendByte(1, 8'h07, a);
      waitIdle(1, f);
      checkEq("even_busy_fall", f, a + 177);
      drain(1);

      // odd parity on two bytes of opposite data parity
      sendByte(2, 8'h07, a);
      sendByte(2, 8'h00, a);
      drain(2);

      // two stop bits: next start immediately after the 32-cycle stop
      base = nStarts[3];
      sendByte(3, 8'hF0, a);
      sendByte(3, 8'h0F, f);
      waitIdle(3, f);
      checkEq("stop2_gap", starts[3][base + 1] - starts[3][base], 176);
      checkEq("stop2_busy_fall", f, a + 1 + 352);
      drain(3);

      // reset in the middle of data bit 3 with bytes still queued
      sendByte(0, 8'h11, a);
      sendByte(0, 8'h22, f);
      sendByte(0, 8'h33, f);
      while (cyc < a + 1 + 64 + 8) @(negedge clk);
      rst_n = 1'b0;
      rstEpoch++;
      sb.delete();
      #1;
      checkEq("midreset_txd", txd[0], 1);
      checkEq("midreset_count", cnt[0], 0);
      checkEq("midreset_busy", busy[0], 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = nStarts[0];
      lows = 0;
      repeat (400) begin
         @(negedge clk);
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
      end
      checkEq("post_reset_idle", lows, 0);
      checkEq("post_reset_no_frame", nStarts[0], base);
      sendByte(0, 8'hC3, a);
      drain(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
